// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - PC register, instruction memory, EX redirect and ID hand-off signals of the fetch sequencer
// master: the fetch sequencer (drives pc_load/pc_in, imem_read/imem_addr, if_valid/if_pc/if_instr)
// slave : the surrounding pipeline (drives pc_out, imem_resp/imem_rdata, stall, redirect_valid/redirect_pc)
interface fetch_pc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_out;
    logic             pc_load;
    logic [WIDTH-1:0] pc_in;
    logic             imem_read;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_resp;
    logic [WIDTH-1:0] imem_rdata;
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             if_valid;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_instr;

    modport master (
        input  pc_out, imem_resp, imem_rdata, stall, redirect_valid, redirect_pc,
        output pc_load, pc_in, imem_read, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output pc_out, imem_resp, imem_rdata, stall, redirect_valid, redirect_pc,
        input  pc_load, pc_in, imem_read, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - RV32I instruction-fetch sequencer: PC update, imem reads, output buffer, redirect squash
// clk, rst : clock and synchronous active-high reset
// bus      : master side of fetch_pc_ctrl_if (PC register, imem request/response, redirect, ID hand-off)
module fetch_pc_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} state_t;

    state_t           state_q, state_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [WIDTH-1:0] pend_instr_q, pend_instr_d;
    logic [WIDTH-1:0] sq_addr_q, sq_addr_d;

    logic             imem_read;
    logic [WIDTH-1:0] imem_addr;
    logic             pc_load;
    logic [WIDTH-1:0] pc_in;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_plus4;
    logic             buf_free;
    logic             consume;

    assign target   = bus.redirect_pc & ~WIDTH'(3);
    assign pc_plus4 = bus.pc_out + WIDTH'(4);
    assign consume  = if_valid_q & ~bus.stall;
    assign buf_free = ~if_valid_q | ~bus.stall;

    assign bus.imem_read = imem_read;
    assign bus.imem_addr = imem_addr;
    assign bus.pc_load   = pc_load;
    assign bus.pc_in     = pc_in;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

    always_comb begin
        state_d      = state_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        pend_pc_d    = pend_pc_q;
        pend_instr_d = pend_instr_q;
        sq_addr_d    = sq_addr_q;
        imem_read    = 1'b0;
        imem_addr    = bus.pc_out;
        pc_load      = 1'b0;
        pc_in        = pc_plus4;

        // A consumed buffer empties unless a capture below refills it.
        if (consume) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                    pc_in   = target;
                end
            end
            FETCH: begin
                imem_read = 1'b1;
                if (bus.imem_resp) begin
                    pc_load = 1'b1;
                    if (bus.redirect_valid) begin
                        pc_in = target;
                    end else if (buf_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = bus.pc_out;
                        if_instr_d = bus.imem_rdata;
                    end else begin
                        // Buffer is held by a stalled ID: park the word and stop issuing.
                        pend_pc_d    = bus.pc_out;
                        pend_instr_d = bus.imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // The memory still owns this request; keep presenting it until it completes.
                    sq_addr_d = bus.pc_out;
                    pc_load   = 1'b1;
                    pc_in     = target;
                    state_d   = SQUASH;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                    pc_in   = target;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pend_pc_q;
                    if_instr_d = pend_instr_q;
                    state_d    = FETCH;
                end
            end
            SQUASH: begin
                imem_read = 1'b1;
                imem_addr = sq_addr_q;
                if (bus.redirect_valid) begin
                    pc_load = 1'b1;
                    pc_in   = target;
                end
                if (bus.imem_resp) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect flushes whatever ID would see next, ahead of stall.
        if (bus.redirect_valid) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            pend_pc_q    <= '0;
            pend_instr_q <= '0;
            sq_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            pend_pc_q    <= pend_pc_d;
            pend_instr_q <= pend_instr_d;
            sq_addr_q    <= sq_addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl against a queue-based fetch model
module tb_fetch_pc_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_pc_ctrl_if #(.WIDTH(W)) bus ();
    fetch_pc_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a queue of delivered-but-unconsumed {pc, instr} words,
    // the model PC, and whether the outstanding memory request is wrong-path.
    bit           m_started;
    bit           m_wp;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_sq;
    logic [2*W-1:0] q[$];

    // Memory model: each request is answered after mem_len cycles (1 = same cycle).
    bit mem_busy;
    int mem_cnt;
    int mem_len;
    int mem_lat;

    // Observations from the most recent cycle, used by the literal checks.
    logic         o_read, o_valid, o_load;
    logic [W-1:0] o_addr, o_ifpc, o_pcin;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_resp      = 1'b0;
        bus.imem_rdata     = '0;
        @(posedge clk);
        #1 bus.pc_out = 32'h60;
        @(posedge clk);
        @(negedge clk);
        chk("rst_imem_read", bus.imem_read, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_pc", bus.if_pc, 0);
        chk("rst_if_instr", bus.if_instr, 0);
        rst       = 1'b0;
        m_started = 1'b0;
        m_wp      = 1'b0;
        m_pc      = 32'h60;
        m_sq      = '0;
        q.delete();
        mem_busy  = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input bit st, input bit rv, input logic [W-1:0] rp);
        bit           e_read, e_load, resp;
        logic [W-1:0] e_addr, e_pcin, t, rdata;

        e_read = m_started && (q.size() < 2);
        e_addr = m_wp ? m_sq : m_pc;

        o_read  = bus.imem_read;
        o_addr  = bus.imem_addr;
        o_valid = bus.if_valid;
        o_ifpc  = bus.if_pc;
        chk("imem_read", o_read, e_read);
        if (e_read) chk("imem_addr", o_addr, e_addr);
        chk("pc_out", bus.pc_out, m_pc);
        chk("if_valid", o_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("if_pc", o_ifpc, q[0][2*W-1:W]);
            chk("if_instr", bus.if_instr, q[0][W-1:0]);
        end

        resp = 1'b0;
        if (bus.imem_read) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 1;
                mem_len  = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
            end else begin
                mem_cnt++;
            end
            resp = (mem_cnt >= mem_len);
            if (resp) mem_busy = 1'b0;
        end
        rdata              = $urandom();
        bus.imem_resp      = resp;
        bus.imem_rdata     = rdata;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        #1;

        t      = {rp[W-1:2], 2'b00};
        e_load = 1'b0;
        e_pcin = '0;
        if (rv) begin
            e_load = 1'b1;
            e_pcin = t;
        end else if (e_read && resp && !m_wp) begin
            e_load = 1'b1;
            e_pcin = m_pc + 32'd4;
        end
        o_load = bus.pc_load;
        o_pcin = bus.pc_in;
        chk("pc_load", o_load, e_load);
        if (e_load) chk("pc_in", o_pcin, e_pcin);

        if (rv) begin
            q.delete();
            if (e_read && !resp && !m_wp) begin
                m_wp = 1'b1;
                m_sq = m_pc;
            end else if (e_read && resp) begin
                m_wp = 1'b0;
            end
            m_pc = t;
        end else begin
            if (q.size() > 0 && !st) void'(q.pop_front());
            if (e_read && resp) begin
                if (m_wp) begin
                    m_wp = 1'b0;
                end else begin
                    q.push_back({m_pc, rdata});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_started = 1'b1;

        @(posedge clk);
        #1;
        if (o_load === 1'b1) bus.pc_out = o_pcin;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit           st, rv;
        logic [W-1:0] rp;

        // Zero-wait memory, no stall: one instruction per cycle.
        mem_lat = 1;
        do_reset();
        cycle(0, 0, 0); chk("t1_idle_read", o_read, 0);
        cycle(0, 0, 0); chk("t1_addr0", o_addr, 32'h60); chk("t1_valid0", o_valid, 0);
        cycle(0, 0, 0); chk("t1_addr1", o_addr, 32'h64); chk("t1_valid1", o_valid, 1); chk("t1_ifpc1", o_ifpc, 32'h60);
        cycle(0, 0, 0); chk("t1_addr2", o_addr, 32'h68); chk("t1_ifpc2", o_ifpc, 32'h64);

        // Three-cycle memory latency.
        mem_lat = 3;
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("t2_addr_hold", o_addr, 32'h60);
            chk("t2_read_hold", o_read, 1);
        end
        cycle(0, 0, 0); chk("t2_valid", o_valid, 1); chk("t2_ifpc", o_ifpc, 32'h60); chk("t2_next_addr", o_addr, 32'h64);

        // Four stall cycles with a full buffer: one word parks in pending.
        mem_lat = 1;
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0); chk("t3_hold_read", o_read, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0); chk("t3_ifpc_a", o_ifpc, 32'h60);
        cycle(0, 0, 0); chk("t3_ifpc_b", o_ifpc, 32'h64); chk("t3_addr_b", o_addr, 32'h68);
        cycle(0, 0, 0); chk("t3_ifpc_c", o_ifpc, 32'h68);

        // Redirect to an unaligned target.
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h1003); chk("t4_load", o_load, 1); chk("t4_pcin", o_pcin, 32'h1000);
        cycle(0, 0, 0); chk("t4_valid", o_valid, 0); chk("t4_addr", o_addr, 32'h1000);

        // Redirect while the read at 0x70 is still in flight.
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        mem_lat = 2;
        cycle(0, 1, 32'h2000); chk("t5_addr_a", o_addr, 32'h70);
        cycle(0, 0, 0); chk("t5_addr_b", o_addr, 32'h70); chk("t5_read_b", o_read, 1); chk("t5_valid_b", o_valid, 0);
        cycle(0, 0, 0); chk("t5_target", o_addr, 32'h2000);

        // Redirect plus stall in HOLD, then PC wrap past the top of memory.
        mem_lat = 1;
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 32'hFFFF_FFFF); chk("t6_hold_read", o_read, 0); chk("t6_load", o_load, 1); chk("t6_pcin", o_pcin, 32'hFFFF_FFFC);
        cycle(0, 0, 0); chk("t6_valid", o_valid, 0); chk("t6_addr", o_addr, 32'hFFFF_FFFC); chk("t6_wrap_pcin", o_pcin, 32'h0);
        cycle(0, 0, 0); chk("t6_wrap_addr", o_addr, 32'h0); chk("t6_ifpc", o_ifpc, 32'hFFFF_FFFC);

        // Randomized traffic with variable latency, stalls, redirects and resets.
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            st = ($urandom_range(0, 99) < 35);
            rv = ($urandom_range(0, 99) < 8);
            rp = $urandom();
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
            cycle(st, rv, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Sequencer for the instruction-fetch stage of the pipelined RV32I core. It owns the load enable and next-value input of the PC register, and issues instruction-memory reads at the current PC. It holds fetched instructions in a one-entry output buffer plus a one-entry pending slot, and applies branch/jump redirects from EX, squashing any read already in flight.

## Interface
- WIDTH, 32, address/data width; PC increment is fixed at 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- pc_out  in  WIDTH  current PC from the PC register, which resets itself to 0x60
- pc_load  out  1  PC register load enable
- pc_in  out  WIDTH  next PC value
- imem_read  out  1  instruction read request
- imem_addr  out  WIDTH  read address
- imem_resp  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  WIDTH  instruction word
- stall  in  1  ID cannot accept this cycle
- redirect_valid  in  1  EX branch taken / jump
- redirect_pc  in  WIDTH  redirect target
- if_valid  out  1  if_instr/if_pc valid to ID
- if_pc  out  WIDTH  PC of buffered instruction
- if_instr  out  WIDTH  buffered instruction

## Operation
- States: IDLE, FETCH, HOLD, SQUASH.
- Buffer consume: ID takes the buffer in a cycle where if_valid=1 and stall=0.
- Buffer free this cycle: if_valid=0, or stall=0.
- Redirect target T = {redirect_pc[WIDTH-1:2],2'b00}.
- pc_in arithmetic is pc_out+4, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x0).
- IDLE:
  - imem_read=0, pc_load=0.
  - Next cycle go to FETCH. Redirect in IDLE: pc_load=1, pc_in=T, then FETCH.
- FETCH:
  - imem_read=1, imem_addr=pc_out.
  - resp with redirect: discard rdata; pc_load=1, pc_in=T; stay FETCH.
  - resp, no redirect, buffer free: if_instr<=rdata, if_pc<=pc_out, if_valid<=1; pc_load=1, pc_in=pc_out+4; stay FETCH.
  - resp, no redirect, buffer full and stall=1: pending<=(pc_out, rdata); pc_load=1, pc_in=pc_out+4; go to HOLD.
  - No resp, redirect: sq_addr<=pc_out; pc_load=1, pc_in=T; go to SQUASH.
  - No resp, no redirect: hold the request with the address stable.
- HOLD:
  - imem_read=0, pc_load=0.
  - stall=0 and no redirect: buffer<=pending, if_valid stays 1; go to FETCH.
  - Redirect: drop buffer and pending; pc_load=1, pc_in=T; go to FETCH.
- SQUASH:
  - imem_read=1, imem_addr=sq_addr; the old request stays stable until it completes.
  - resp: discard rdata; go to FETCH.
  - A further redirect in SQUASH: pc_load=1, pc_in=T; stay SQUASH.
- Flush: redirect_valid clears if_valid on the next edge in every state; redirect has priority over stall.
- Otherwise, if_valid<=0 on consume when no new capture occurs.
- pc_load=0 whenever not stated above; pc_in is then don't-care.

## Timing
- Reset values (outputs and state): state=IDLE, imem_read=0, pc_load=0, if_valid=0, if_pc=0, if_instr=0, pending empty.
- Reset mid-transaction aborts the request the same edge.
- The first read is issued 1 cycle after reset deasserts, at pc_out=0x60.
- With zero-wait memory, imem_resp arrives the same cycle as imem_read. Throughput is then 1 instruction/cycle, and if_valid rises 1 cycle after the resp.
- imem_addr and imem_read are held stable from request until imem_resp, including across a redirect (SQUASH).
- The redirect target appears on imem_addr 1 cycle after redirect_valid (FETCH/HOLD/IDLE), or 1 cycle after the squashed resp (SQUASH).
- No instruction from the wrong path reaches ID with if_valid=1 after the edge on which redirect_valid is sampled.

## Test plan
- Reset then zero-wait memory, stall=0 -> reads at 0x60, 0x64, 0x68. if_valid=1 from cycle 2 with if_pc 0x60, 0x64, … on consecutive cycles.
- 3-cycle memory latency -> imem_addr stays 0x60 for 3 cycles. if_pc=0x60 is valid the cycle after resp, and the next read is at 0x64.
- stall=1 for 4 cycles with buffer full -> one extra resp goes to pending and state goes to HOLD with imem_read=0. On release, if_pc advances 0x64 then 0x68 with no loss or duplication.
- redirect_valid with redirect_pc=0x1003, no resp pending -> pc_in=0x1000, pc_load=1, if_valid=0 next cycle, next read at 0x1000.
- redirect while a read at 0x70 is in flight (latency 2) -> imem_addr stays 0x70 until resp. That rdata is discarded, then a read at the target follows.
- Redirect and stall in the same cycle in HOLD -> buffer and pending are dropped. Fetch resumes at the target; PC wrap from 0xFFFFFFFC gives a next read at 0x0.
